// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: frame start / inter-frame gap / frame-count sequencing for the XGMII test-frame generator.
// Optional per-second frame and byte statistics are built when TX_SCHED_STATS_EN is defined.
module tx_frame_scheduler #(
  parameter  int unsigned CLK_FREQ = 156250000,
  parameter  int unsigned MIN_GAP  = 2,
  parameter  int unsigned LEN_MIN  = 64,
  parameter  int unsigned LEN_MAX  = 1518,
  localparam int unsigned LEN_W    = 16,
  localparam int unsigned CNT_W    = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tx_enable,
  input  logic [LEN_W-1:0] tx_frame_len,
  input  logic [CNT_W-1:0] tx_inter_frame_gap,
  input  logic [CNT_W-1:0] tx_frame_count,
  input  logic             gen_ready,
  input  logic             gen_done,
  output logic             gen_start,
  output logic [LEN_W-1:0] gen_frame_len,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] tx_sent,
  output logic [CNT_W-1:0] tx_pps,
  output logic [CNT_W-1:0] tx_throughput
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [LEN_W-1:0] LEN_LO  = LEN_W'(LEN_MIN);
  localparam logic [LEN_W-1:0] LEN_HI  = LEN_W'(LEN_MAX);
  localparam logic [CNT_W-1:0] GAP_MIN = CNT_W'(MIN_GAP);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_en_q;
  logic             r_gen_start;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_sent;
  logic             r_busy;
  logic             r_done;

  logic             w_en_rise;
  logic             w_done_evt;
  logic             w_count_hit;
  logic [CNT_W-1:0] w_sent_base;
  logic [LEN_W-1:0] w_len_clamped;
  logic [CNT_W-1:0] w_gap_eff;

  assign w_en_rise     = tx_enable && !r_en_q && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_done_evt    = (r_state == ST_WAIT_DONE) && gen_done;
  assign w_sent_base   = w_en_rise ? '0 : r_sent;
  assign w_count_hit   = (tx_frame_count != '0) && (r_sent >= tx_frame_count);
  assign w_len_clamped = (tx_frame_len < LEN_LO) ? LEN_LO :
                         (tx_frame_len > LEN_HI) ? LEN_HI : tx_frame_len;
  assign w_gap_eff     = (tx_inter_frame_gap < GAP_MIN) ? GAP_MIN : tx_inter_frame_gap;

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (tx_enable && (tx_frame_count == '0 || w_sent_base < tx_frame_count))
          w_state_nxt = ST_START;
      end
      ST_START: begin
        if (gen_ready) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (gen_done) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          if (w_count_hit)     w_state_nxt = ST_DONE;
          else if (!tx_enable) w_state_nxt = ST_IDLE;
          else                 w_state_nxt = ST_START;
        end
      end
      ST_DONE: begin
        if (!tx_enable) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, handshake and run counters. The idle words seen by the generator are the
  // GAP cycles plus the START cycle, so GAP is held for gap-1 cycles (MIN_GAP >= 2).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_en_q      <= 1'b0;
      r_gen_start <= 1'b0;
      r_len       <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_sent      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_en_q      <= tx_enable;
      r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_gen_start <= (r_state == ST_START) && gen_ready;

      if (r_state == ST_START && gen_ready) begin
        r_len <= w_len_clamped;
        r_gap <= w_gap_eff;
      end

      if (w_en_rise)
        r_sent <= '0;
      else if (w_done_evt && r_sent != '1)
        r_sent <= r_sent + CNT_W'(1);

      if (w_done_evt)
        r_gap_cnt <= r_gap - CNT_W'(2);
      else if (r_state == ST_GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - CNT_W'(1);
    end
  end

  assign gen_start     = r_gen_start;
  assign gen_frame_len = r_len;
  assign tx_busy       = r_busy;
  assign tx_done       = r_done;
  assign tx_sent       = r_sent;

`ifdef TX_SCHED_STATS_EN
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] r_acc_frames;
  logic [CNT_W-1:0] r_acc_bytes;
  logic [CNT_W-1:0] r_pps;
  logic [CNT_W-1:0] r_tput;
  logic [CNT_W-1:0] w_frames_nxt;
  logic [CNT_W-1:0] w_bytes_nxt;
  logic [CNT_W:0]   w_bytes_sum;

  // Saturating window accumulators including the current cycle's completion
  always_comb begin
    w_frames_nxt = r_acc_frames;
    w_bytes_sum  = {1'b0, r_acc_bytes};
    if (w_done_evt) begin
      if (r_acc_frames != '1) w_frames_nxt = r_acc_frames + CNT_W'(1);
      w_bytes_sum = {1'b0, r_acc_bytes} + (CNT_W + 1)'(r_len);
    end
    w_bytes_nxt = w_bytes_sum[CNT_W] ? '1 : w_bytes_sum[CNT_W-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sec_cnt    <= '0;
      r_acc_frames <= '0;
      r_acc_bytes  <= '0;
      r_pps        <= '0;
      r_tput       <= '0;
    end else if (r_sec_cnt == '0) begin
      r_sec_cnt    <= SEC_LAST;
      r_pps        <= w_frames_nxt;
      r_tput       <= w_bytes_nxt;
      r_acc_frames <= '0;
      r_acc_bytes  <= '0;
    end else begin
      r_sec_cnt    <= r_sec_cnt - CNT_W'(1);
      r_acc_frames <= w_frames_nxt;
      r_acc_bytes  <= w_bytes_nxt;
    end
  end

  assign tx_pps        = r_pps;
  assign tx_throughput = r_tput;
`else
  localparam int unsigned unused_clk_freq = CLK_FREQ;

  assign tx_pps        = '0;
  assign tx_throughput = '0;
`endif

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: directed scenarios and randomized runs checked against a
// frame-timing reference model (start times, clamped lengths, counts, gap and stats windows).
`timescale 1ns/1ps
module tb_tx_frame_scheduler;

  localparam int CLK_FREQ = 1000;
  localparam int MIN_GAP  = 2;
  localparam int LEN_MIN  = 64;
  localparam int LEN_MAX  = 1518;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        tx_enable;
  logic [15:0] tx_frame_len;
  logic [31:0] tx_inter_frame_gap;
  logic [31:0] tx_frame_count;
  logic        gen_ready;
  logic        gen_done;
  logic        gen_start;
  logic [15:0] gen_frame_len;
  logic        tx_busy;
  logic        tx_done;
  logic [31:0] tx_sent;
  logic [31:0] tx_pps;
  logic [31:0] tx_throughput;

  tx_frame_scheduler #(
    .CLK_FREQ (CLK_FREQ),
    .MIN_GAP  (MIN_GAP),
    .LEN_MIN  (LEN_MIN),
    .LEN_MAX  (LEN_MAX)
  ) dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .tx_enable          (tx_enable),
    .tx_frame_len       (tx_frame_len),
    .tx_inter_frame_gap (tx_inter_frame_gap),
    .tx_frame_count     (tx_frame_count),
    .gen_ready          (gen_ready),
    .gen_done           (gen_done),
    .gen_start          (gen_start),
    .gen_frame_len      (gen_frame_len),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_sent            (tx_sent),
    .tx_pps             (tx_pps),
    .tx_throughput      (tx_throughput)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int          q_start[$];
  logic [15:0] q_len[$];
  int          q_done[$];

  always @(negedge sys_clk) begin
    if (gen_start) begin
      q_start.push_back(cyc);
      q_len.push_back(gen_frame_len);
    end
  end

  // Generator model: gen_done pulse gen_delay cycles after each gen_start
  int gen_delay = 8;
  int spur_req  = 0;
  int spur_ack  = 0;
  initial begin
    gen_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (gen_start) begin
        repeat (gen_delay) @(negedge sys_clk);
        gen_done = 1'b1;
        q_done.push_back(cyc);
        @(negedge sys_clk);
        gen_done = 1'b0;
      end else if (spur_req != spur_ack) begin
        gen_done = 1'b1;
        @(negedge sys_clk);
        gen_done = 1'b0;
        spur_ack = spur_req;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] clamp_len(input logic [15:0] l);
    if (int'(l) < LEN_MIN) return 16'(LEN_MIN);
    if (int'(l) > LEN_MAX) return 16'(LEN_MAX);
    return l;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget && q_start.size() < n; i++) @(negedge sys_clk);
  endtask

  task automatic clear_q();
    q_start.delete();
    q_len.delete();
    q_done.delete();
  endtask

  // Model: first start 2 cycles after enable; each next start = done + max(gap,MIN_GAP) + 1
  task automatic run_check(input string tag, input int cnt, input logic [15:0] len,
                           input int gap, input int d);
    int          exp_s;
    int          eff_gap;
    logic [15:0] exp_len;
    tx_frame_len       = len;
    tx_inter_frame_gap = 32'(gap);
    tx_frame_count     = 32'(cnt);
    gen_delay          = d;
    gen_ready          = 1'b1;
    clear_q();
    @(negedge sys_clk);
    tx_enable = 1'b1;
    exp_s     = cyc + 2;
    eff_gap   = (gap < MIN_GAP) ? MIN_GAP : gap;
    exp_len   = clamp_len(len);
    for (int k = 0; k < cnt; k++) begin
      wait_starts(k + 1, d + eff_gap + 20);
      if (q_start.size() > k) begin
        chk({tag, "_start_cycle"}, 32'(q_start[k]), 32'(exp_s));
        chk({tag, "_frame_len"}, 32'(q_len[k]), 32'(exp_len));
      end else begin
        chk({tag, "_start_missing"}, 32'(q_start.size()), 32'(k + 1));
      end
      exp_s = exp_s + d + eff_gap + 1;
    end
    for (int i = 0; i < d + eff_gap + 20 && !tx_done; i++) @(negedge sys_clk);
    chk({tag, "_tx_done"}, 32'(tx_done), 32'd1);
    chk({tag, "_tx_busy"}, 32'(tx_busy), 32'd0);
    chk({tag, "_tx_sent"}, tx_sent, 32'(cnt));
    chk({tag, "_start_total"}, 32'(q_start.size()), 32'(cnt));
    tx_enable = 1'b0;
    tick(2);
    chk({tag, "_done_clear"}, 32'(tx_done), 32'd0);
  endtask

  logic [15:0] len_pool [8] = '{16'd0, 16'd63, 16'd64, 16'd65, 16'd1517, 16'd1518, 16'd1519, 16'hFFFF};

  initial begin
    int s0;
    int m;
    int t_quiet;
    int base;
    sys_rst_n          = 1'b0;
    tx_enable          = 1'b0;
    tx_frame_len       = 16'd64;
    tx_inter_frame_gap = 32'd0;
    tx_frame_count     = 32'd0;
    gen_ready          = 1'b1;
    tick(3);
    chk("rst_gen_start", 32'(gen_start), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_sent", tx_sent, 32'd0);
    chk("rst_len", 32'(gen_frame_len), 32'd0);
    chk("rst_pps", tx_pps, 32'd0);
    chk("rst_tput", tx_throughput, 32'd0);
    sys_rst_n = 1'b1;
    tick(2);

    // Basic run: start-to-start = 8 + 12 + 1 = 21
    run_check("t1", 3, 16'd64, 12, 8);
`ifndef TX_SCHED_STATS_EN
    chk("t1_pps_tied", tx_pps, 32'd0);
    chk("t1_tput_tied", tx_throughput, 32'd0);
`endif

    // Clamp both ways, gap 0 floors at MIN_GAP, length change applies at next frame only
    tx_frame_len = 16'd20; tx_inter_frame_gap = 32'd0; tx_frame_count = 32'd2;
    gen_delay = 5; clear_q();
    @(negedge sys_clk);
    tx_enable = 1'b1;
    wait_starts(1, 10);
    tx_frame_len = 16'd9000;
    tick(1);
    chk("t2_len_stable", 32'(gen_frame_len), 32'd64);
    wait_starts(2, 30);
    if (q_start.size() >= 2) begin
      chk("t2_len0", 32'(q_len[0]), 32'd64);
      chk("t2_len1", 32'(q_len[1]), 32'd1518);
      chk("t2_spacing", 32'(q_start[1] - q_start[0]), 32'(5 + MIN_GAP + 1));
    end else begin
      chk("t2_starts", 32'(q_start.size()), 32'd2);
    end
    tick(15);
    chk("t2_done", 32'(tx_done), 32'd1);
    tx_enable = 1'b0;
    tick(2);

    // Continuous run, enable dropped during WAIT_DONE: frame completes, gap, then IDLE
    tx_frame_len = 16'd300; tx_inter_frame_gap = 32'd4; tx_frame_count = 32'd0;
    gen_delay = 20; clear_q();
    @(negedge sys_clk);
    tx_enable = 1'b1;
    wait_starts(1, 10);
    tick(3);
    tx_enable = 1'b0;
    t_quiet = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (!tx_busy) begin
        t_quiet = cyc;
        break;
      end
    end
    chk("t3_quiet", 32'(tx_busy), 32'd0);
    chk("t3_starts", 32'(q_start.size()), 32'd1);
    chk("t3_sent", tx_sent, 32'd1);
    chk("t3_not_done", 32'(tx_done), 32'd0);
    if (q_done.size() > 0) chk("t3_idle_cycle", 32'(t_quiet), 32'(q_done[0] + 4));
    else chk("t3_done_seen", 32'(q_done.size()), 32'd1);
    // gen_done outside WAIT_DONE is ignored
    spur_req++;
    tick(5);
    chk("t3_spurious_done", tx_sent, 32'd1);

    // gen_ready held low in START for 50 cycles
    tx_frame_len = 16'd200; tx_inter_frame_gap = 32'd2; tx_frame_count = 32'd1;
    gen_delay = 3; gen_ready = 1'b0; clear_q();
    @(negedge sys_clk);
    tx_enable = 1'b1;
    tick(50);
    chk("t4_no_start", 32'(q_start.size()), 32'd0);
    chk("t4_busy_stall", 32'(tx_busy), 32'd1);
    gen_ready = 1'b1;
    m = cyc;
    wait_starts(1, 10);
    if (q_start.size() > 0) chk("t4_start_cycle", 32'(q_start[0]), 32'(m + 1));
    tick(20);
    chk("t4_single_pulse", 32'(q_start.size()), 32'd1);
    chk("t4_done", 32'(tx_done), 32'd1);
    tx_enable = 1'b0;
    tick(2);

    // Reset during WAIT_DONE, then restart from tx_sent = 0
    tx_frame_len = 16'd128; tx_inter_frame_gap = 32'd2; tx_frame_count = 32'd0;
    gen_delay = 6; clear_q();
    @(negedge sys_clk);
    tx_enable = 1'b1;
    wait_starts(3, 60);
    tick(2);
    chk("t6_pre_sent", tx_sent, 32'd2);
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_gen_start", 32'(gen_start), 32'd0);
    chk("t6_rst_busy", 32'(tx_busy), 32'd0);
    chk("t6_rst_sent", tx_sent, 32'd0);
    chk("t6_rst_len", 32'(gen_frame_len), 32'd0);
    tx_enable = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    tick(12);
    chk("t6_idle_after", 32'(tx_busy), 32'd0);
    run_check("t6_restart", 2, 16'd128, 3, 4);

    // Randomized runs against the model
    for (int r = 0; r < 6; r++) begin
      logic [15:0] l;
      if ($urandom_range(0, 1) == 0) l = len_pool[$urandom_range(0, 7)];
      else l = 16'($urandom_range(0, 2000));
      run_check($sformatf("rnd%0d", r), int'($urandom_range(1, 4)), l,
                int'($urandom_range(0, 7)), int'($urandom_range(1, 12)));
    end

`ifdef TX_SCHED_STATS_EN
    // Stats window: 10 frames of 100 bytes inside one window
    sys_rst_n = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    base = cyc;
    run_check("t5", 10, 16'd100, 2, 8);
    while (cyc < base + CLK_FREQ + 100) @(negedge sys_clk);
    chk("t5_pps", tx_pps, 32'd10);
    chk("t5_tput", tx_throughput, 32'd1000);
    tick(CLK_FREQ);
    chk("t5_pps_empty", tx_pps, 32'd0);
    chk("t5_tput_empty", tx_throughput, 32'd0);
`else
    base = cyc;
    tick(10);
    chk("t5_pps_absent", tx_pps, 32'd0);
    chk("t5_tput_absent", tx_throughput, 32'(base - base));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
